axi_demux_n: RTL and testbench
==============================

Name: axi_demux_n

Overview:
Parametrised AXI4-Stream 1-to-N packet demultiplexer. It is the successor to the fixed 4-way demux in the accelerator path.
- Routes whole packets from one slave stream to one of NUM_PORTS master streams.
- The destination is latched on the first beat of each packet.
- Packets addressed to inactive or out-of-range ports are discarded and counted.
- An optional registered output stage is available for timing closure.

Parameters:
C_AXIS_DATA_WIDTH, 64, tdata width per stream
C_NUM_PORTS, 4, number of master outputs (1..16)
C_DEST_WIDTH, 2, width of dest; must satisfy C_NUM_PORTS <= 2**C_DEST_WIDTH
C_ACTIVE_MASK, {C_NUM_PORTS{1'b1}}, bit i=1: port i connected; bit i=0: packets to port i are dropped
C_CNT_WIDTH, 16, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
S_AXIS_TDATA  in  C_AXIS_DATA_WIDTH  input data
S_AXIS_TVALID  in  1  input valid
S_AXIS_TLAST  in  1  input end of packet
S_AXIS_TREADY  out  1  input ready
dest  in  C_DEST_WIDTH  destination port, sampled on packet start
M_AXIS_TDATA  out  C_NUM_PORTS*C_AXIS_DATA_WIDTH  flattened outputs; port i at [i*W +: W]
M_AXIS_TVALID  out  C_NUM_PORTS  per-port valid
M_AXIS_TLAST  out  C_NUM_PORTS  per-port last
M_AXIS_TREADY  in  C_NUM_PORTS  per-port ready
drop_count  out  C_CNT_WIDTH  dropped packet count, saturating
busy  out  1  high while a packet is in progress (state != IDLE)

Behaviour:
- Reset: state=IDLE, sel=0, drop_count=0. All M_AXIS_TVALID=0, S_AXIS_TREADY=0, busy=0. With AXI_DEMUX_OUT_REG_EN, all skid entries are emptied.
- States: IDLE, ROUTE, DROP.
- IDLE:
  - S_AXIS_TREADY=0 and no output valid.
  - When S_AXIS_TVALID=1, latch sel<=dest.
  - Go to ROUTE if dest < C_NUM_PORTS and C_ACTIVE_MASK[dest]=1; otherwise go to DROP.
  - This costs one bubble cycle per packet. dest is ignored outside IDLE.
- ROUTE:
  - M_AXIS_TVALID[sel]=S_AXIS_TVALID; all other valids are 0.
  - S_AXIS_TREADY = ready of port sel.
  - On S_AXIS_TVALID & S_AXIS_TREADY & S_AXIS_TLAST, go to IDLE.
- DROP:
  - S_AXIS_TREADY=1 and all M_AXIS_TVALID=0.
  - On the accepted TLAST beat: go to IDLE, and drop_count increments by 1, saturating at all-ones.
- Data/last fan-out: TDATA and TLAST are broadcast to every port; only TVALID is qualified.
- Single-beat packet (TLAST on first beat): IDLE -> ROUTE/DROP -> IDLE, consuming the beat in the second state. A packet therefore occupies at least 2 cycles.
- Back-pressure: M_AXIS_TREADY[sel]=0 stalls the input indefinitely with no data loss. Readiness of non-selected ports is ignored.
- Handshake rules: TVALID is never dependent on TREADY. Once asserted, output valid/data are held stable until accepted.
- Reset mid-packet: returns to IDLE immediately. The remainder of the interrupted packet is treated as a new packet; upstream must also be reset.
- Parameter checks: an elaboration-time error is raised if C_NUM_PORTS > 2**C_DEST_WIDTH.

Optional Feature:
Macro: AXI_DEMUX_OUT_REG_EN
- Defined:
  - Each port gets a 2-entry skid buffer (registered data/last/valid).
  - In ROUTE, S_AXIS_TREADY = not-full of the skid for port sel.
  - The selected output lags the input by 1 cycle.
  - Full throughput is sustained when downstream is ready.
  - The ROUTE->IDLE transition occurs when TLAST is accepted into the skid, not when it leaves.
  - busy stays high until all skids are empty.
  - M_AXIS paths are fully registered.
- Undefined:
  - Purely combinational datapath as described above, with zero latency.

Test Plan:
- 3 packets of 4 beats with dest=0,2,3 and all readies=1 -> each appears only on the addressed port with matching data and TLAST on beat 4; 1 idle cycle between packets (2 with OUT_REG).
- C_ACTIVE_MASK=4'b1011, packet of 5 beats to dest=2 -> S_AXIS_TREADY=1 for all beats, no M valid, drop_count 0->1.
- C_NUM_PORTS=3, C_DEST_WIDTH=2, dest=3 -> packet dropped, drop_count increments, next packet to dest=1 delivered intact.
- Port 1 TREADY toggling 1/0 randomly over a 16-beat packet -> no beat lost or duplicated. dest changing mid-packet is ignored. Other ports' valids stay 0.
- 1-beat packets back-to-back to alternating ports 0/1 -> each delivered once; busy pulses each packet.
- rst asserted on beat 2 of a 6-beat packet -> next cycle: all valids 0, S_AXIS_TREADY=0, drop_count=0, state IDLE; drop_count preload at all-ones saturates on a further drop.

Source files
------------

// File: rtl/axi_demux_n.sv
// rtl/axi_demux_n.sv - AXI4-Stream 1-to-N packet demux with saturating drop counter
// Define AXI_DEMUX_OUT_REG_EN for a registered 2-entry skid buffer per master port.
module axi_demux_n #(
  parameter int                     C_AXIS_DATA_WIDTH = 64,
  parameter int                     C_NUM_PORTS       = 4,
  parameter int                     C_DEST_WIDTH      = 2,
  parameter logic [C_NUM_PORTS-1:0] C_ACTIVE_MASK     = {C_NUM_PORTS{1'b1}},
  parameter int                     C_CNT_WIDTH       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]             S_AXIS_TDATA,
  input  logic                                     S_AXIS_TVALID,
  input  logic                                     S_AXIS_TLAST,
  output logic                                     S_AXIS_TREADY,
  input  logic [C_DEST_WIDTH-1:0]                  dest,
  output logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [C_NUM_PORTS-1:0]                   M_AXIS_TVALID,
  output logic [C_NUM_PORTS-1:0]                   M_AXIS_TLAST,
  input  logic [C_NUM_PORTS-1:0]                   M_AXIS_TREADY,
  output logic [C_CNT_WIDTH-1:0]                   drop_count,
  output logic                                     busy
);
  localparam int W   = C_AXIS_DATA_WIDTH;
  localparam int N   = C_NUM_PORTS;
  localparam int EXT = 2**C_DEST_WIDTH;

  if (N > EXT) begin : g_dest_width_check
    $error("axi_demux_n: C_NUM_PORTS exceeds 2**C_DEST_WIDTH");
  end
  if (N < 1 || N > 16) begin : g_num_ports_check
    $error("axi_demux_n: C_NUM_PORTS must be within 1..16");
  end

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                  state;
  logic [C_DEST_WIDTH-1:0] sel;
  logic [EXT-1:0]          active_ext;
  logic [EXT-1:0]          route_ready_ext;
  logic [N-1:0]            route_ready;
  logic [N-1:0]            port_sel;
  logic                    s_fire;
  logic                    skid_busy;

  // Widening to the full dest range makes out-of-range ports read as inactive.
  assign active_ext      = EXT'(C_ACTIVE_MASK);
  assign route_ready_ext = EXT'(route_ready);

  always_comb begin
    port_sel = '0;
    for (int i = 0; i < N; i++) begin
      port_sel[i] = (state == ROUTE) && (sel == C_DEST_WIDTH'(i));
    end
  end

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (state)
      ROUTE:   S_AXIS_TREADY = route_ready_ext[sel];
      DROP:    S_AXIS_TREADY = 1'b1;
      default: S_AXIS_TREADY = 1'b0;
    endcase
  end

  assign s_fire = S_AXIS_TVALID && S_AXIS_TREADY;
  assign busy   = (state != IDLE) || skid_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Waiting for empty skids keeps packets from different ports strictly ordered.
          if (S_AXIS_TVALID && !skid_busy) begin
            sel   <= dest;
            state <= active_ext[dest] ? ROUTE : DROP;
          end
        end
        ROUTE: begin
          if (s_fire && S_AXIS_TLAST) state <= IDLE;
        end
        DROP: begin
          if (s_fire && S_AXIS_TLAST) begin
            state <= IDLE;
            if (drop_count != '1) drop_count <= drop_count + C_CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_DEMUX_OUT_REG_EN
  logic [N-1:0] skid_nonempty;

  for (genvar i = 0; i < N; i++) begin : g_skid
    logic [1:0]   cnt;
    logic [W-1:0] d0, d1;
    logic         l0, l1;
    logic         push, pop;

    assign push = port_sel[i] && S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop  = (cnt != 2'd0) && M_AXIS_TREADY[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= 2'd0;
      end else begin
        case ({push, pop})
          // Simultaneous push/pop only happens with one entry held.
          2'b11: begin
            d0 <= S_AXIS_TDATA;
            l0 <= S_AXIS_TLAST;
          end
          2'b10: begin
            if (cnt == 2'd0) begin
              d0 <= S_AXIS_TDATA;
              l0 <= S_AXIS_TLAST;
            end else begin
              d1 <= S_AXIS_TDATA;
              l1 <= S_AXIS_TLAST;
            end
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            d0  <= d1;
            l0  <= l1;
            cnt <= cnt - 2'd1;
          end
          default: ;
        endcase
      end
    end

    assign route_ready[i]          = (cnt != 2'd2);
    assign skid_nonempty[i]        = (cnt != 2'd0);
    assign M_AXIS_TVALID[i]        = (cnt != 2'd0);
    assign M_AXIS_TLAST[i]         = l0;
    assign M_AXIS_TDATA[i*W +: W]  = d0;
  end

  assign skid_busy = |skid_nonempty;
`else
  assign route_ready   = M_AXIS_TREADY;
  assign skid_busy     = 1'b0;
  assign M_AXIS_TDATA  = {N{S_AXIS_TDATA}};
  assign M_AXIS_TLAST  = {N{S_AXIS_TLAST}};
  assign M_AXIS_TVALID = port_sel & {N{S_AXIS_TVALID}};
`endif

endmodule

// File: tb/tb_axi_demux_n.sv
// tb/tb_axi_demux_n.sv - scoreboard bench for axi_demux_n (3 ports, port 2 inactive, dest 3 out of range)
module tb_axi_demux_n;
  localparam int W  = 16;
  localparam int N  = 3;
  localparam int DW = 2;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast = 1'b0;
  logic             s_tready;
  logic [DW-1:0]    dest = '0;
  logic [N*W-1:0]   m_tdata;
  logic [N-1:0]     m_tvalid;
  logic [N-1:0]     m_tlast;
  logic [N-1:0]     m_tready = '1;
  logic [CW-1:0]    drop_count;
  logic             busy;

  bit               bp_en = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               busy_rises = 0;
  logic             busy_q = 1'b0;
  logic [DW+W:0]    exp_q[$];
  logic [DW+W:0]    mon_e;

  always #5 clk = ~clk;

  axi_demux_n #(
    .C_AXIS_DATA_WIDTH (W),
    .C_NUM_PORTS       (N),
    .C_DEST_WIDTH      (DW),
    .C_ACTIVE_MASK     (3'b011),
    .C_CNT_WIDTH       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .dest          (dest),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beats leave the DUT in order, so one global queue tagged with the port suffices.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat_queue_size", 64'(exp_q.size()), 64'd1);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_port_last_data", {DW'(i), m_tlast[i], m_tdata[i*W +: W]}, mon_e);
          end
        end
      end
      if (busy && !busy_q) busy_rises++;
    end
    busy_q <= busy;
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      m_tready[1] = 1'($urandom_range(0, 1));
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic last, input int push_port, output int cyc);
    logic [W-1:0] data;
    bit           acc;
    data     = W'($urandom);
    s_tdata  = data;
    s_tlast  = last;
    s_tvalid = 1'b1;
    dest     = d;
    if (push_port >= 0) exp_q.push_back({DW'(push_port), last, data});
    cyc = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!acc && cyc < 200);
    check("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_pkt(input logic [DW-1:0] d, input int n, input bit deliver, input bit scramble,
                          output int cycles);
    int c;
    cycles = 0;
    for (int b = 0; b < n; b++) begin
      drive_beat((b > 0 && scramble) ? DW'($urandom) : d, (b == n - 1), deliver ? int'(d) : -1, c);
      cycles += c;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    int cyc;
    int rises0;
    logic [DW-1:0] tbl_dest [3] = '{2'd0, 2'd1, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      send_pkt(tbl_dest[k], 4, 1'b1, 1'b0, cyc);
      check("pkt4_cycles", 64'(cyc), 64'd5);
    end

    send_pkt(2'd2, 5, 1'b0, 1'b0, cyc);
    check("drop_inactive_cycles", 64'(cyc), 64'd6);
    check("drop_inactive_count", 64'(drop_count), 64'd1);

    send_pkt(2'd3, 3, 1'b0, 1'b0, cyc);
    check("drop_range_count", 64'(drop_count), 64'd2);
    send_pkt(2'd1, 4, 1'b1, 1'b0, cyc);
    check("after_drop_cycles", 64'(cyc), 64'd5);

    bp_en = 1'b1;
    send_pkt(2'd1, 16, 1'b1, 1'b1, cyc);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    m_tready = '1;
    check("bp_min_cycles", 64'(cyc >= 17), 64'd1);

    rises0 = busy_rises;
    for (int k = 0; k < 6; k++) begin
      check("single_busy_before", 64'(busy), 64'd0);
      send_pkt(DW'(k % 2), 1, 1'b1, 1'b0, cyc);
      check("single_cycles", 64'(cyc), 64'd2);
    end
    check("single_busy_pulses", 64'(busy_rises - rises0), 64'd6);

    for (int k = 0; k < 13; k++) send_pkt(2'd2, 1, 1'b0, 1'b0, cyc);
    check("drop_count_full", 64'(drop_count), 64'd15);
    send_pkt(2'd3, 2, 1'b0, 1'b0, cyc);
    check("drop_count_saturated", 64'(drop_count), 64'd15);

    drive_beat(2'd0, 1'b0, 0, cyc);
    drive_beat(2'd0, 1'b0, 0, cyc);
    s_tdata  = W'($urandom);
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_drop_count", 64'(drop_count), 64'd0);
    s_tvalid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(2'd1, 2, 1'b1, 1'b0, cyc);
    check("post_rst_cycles", 64'(cyc), 64'd3);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
